// File: rtl/alpha_mul_seq.sv
// SNOW 3G MULalpha(s) = (s << 8) ^ MULalpha(s[31:24]) built from one iterated MULx byte datapath.
// 245 steps after accept (123 with ALPHA_MUL_UNROLL2_EN); the result is held in DONE until out_ready.
module alpha_mul_seq #(
   parameter logic [7:0] MULX_C = 8'hA9
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_word,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_word,
   output logic        busy
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   // MULalpha byte lanes are alpha^23, alpha^245, alpha^48, alpha^239 times the top byte.
   localparam logic [7:0] CAP_23  = 8'd23;
   localparam logic [7:0] CAP_48  = 8'd48;
   localparam logic [7:0] CAP_239 = 8'd239;
   localparam logic [7:0] CNT_END = 8'd245;

   function automatic logic [7:0] mulx(input logic [7:0] v);
      return {v[6:0], 1'b0} ^ (v[7] ? MULX_C : 8'h00);
   endfunction

   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [7:0]  acc_q, acc_d;
   logic [23:0] lo_q, lo_d;
   logic [7:0]  b23_q, b23_d;
   logic [7:0]  b48_q, b48_d;
   logic [7:0]  b239_q, b239_d;
   logic [31:0] out_word_q, out_word_d;

`ifdef ALPHA_MUL_UNROLL2_EN
   logic [7:0]  step1, step2;
   logic [7:0]  cnt1, cnt2;
`endif

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      acc_d      = acc_q;
      lo_d       = lo_q;
      b23_d      = b23_q;
      b48_d      = b48_q;
      b239_d     = b239_q;
      out_word_d = out_word_q;
`ifdef ALPHA_MUL_UNROLL2_EN
      step1 = mulx(acc_q);
      step2 = mulx(step1);
      cnt1  = cnt_q + 8'd1;
      cnt2  = cnt_q + 8'd2;
`endif

      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               lo_d    = in_word[23:0];
               acc_d   = in_word[31:24];
               cnt_d   = 8'd0;
               b23_d   = 8'd0;
               b48_d   = 8'd0;
               b239_d  = 8'd0;
               state_d = S_RUN;
            end
         end

         S_RUN: begin
`ifdef ALPHA_MUL_UNROLL2_EN
            // cnt stays even, so the odd end count is reached by a lone first step.
            if (cnt1 == CNT_END) begin
               acc_d = step1;
               cnt_d = cnt1;
            end else begin
               acc_d = step2;
               cnt_d = cnt2;
            end
            if (cnt1 == CAP_23)  b23_d  = step1;
            if (cnt2 == CAP_23)  b23_d  = step2;
            if (cnt1 == CAP_48)  b48_d  = step1;
            if (cnt2 == CAP_48)  b48_d  = step2;
            if (cnt1 == CAP_239) b239_d = step1;
            if (cnt2 == CAP_239) b239_d = step2;
`else
            acc_d = mulx(acc_q);
            cnt_d = cnt_q + 8'd1;
            if (cnt_d == CAP_23)  b23_d  = acc_d;
            if (cnt_d == CAP_48)  b48_d  = acc_d;
            if (cnt_d == CAP_239) b239_d = acc_d;
`endif
            if (cnt_d == CNT_END) begin
               out_word_d = {lo_q, 8'h00} ^ {b23_d, acc_d, b48_d, b239_d};
               state_d    = S_DONE;
            end
         end

         S_DONE: begin
            if (out_ready) state_d = S_IDLE;
         end

         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         cnt_q      <= 8'd0;
         acc_q      <= 8'd0;
         lo_q       <= 24'd0;
         b23_q      <= 8'd0;
         b48_q      <= 8'd0;
         b239_q     <= 8'd0;
         out_word_q <= 32'd0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         acc_q      <= acc_d;
         lo_q       <= lo_d;
         b23_q      <= b23_d;
         b48_q      <= b48_d;
         b239_q     <= b239_d;
         out_word_q <= out_word_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign busy      = (state_q != S_IDLE);
   assign out_word  = out_word_q;

endmodule

// File: tb/tb_alpha_mul_seq.sv
// Randomised bench for alpha_mul_seq against a per-cycle behavioural model of MULalpha and its handshake.
module tb_alpha_mul_seq;

`ifdef ALPHA_MUL_UNROLL2_EN
   localparam int LAT = 123;
`else
   localparam int LAT = 245;
`endif

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_word;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_word;
   logic        busy;

   int errors = 0;
   int checks = 0;

   alpha_mul_seq #(.MULX_C(8'hA9)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_word   (in_word),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_word  (out_word),
      .busy      (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // c * x^n in GF(2^8) with x^8 = x^7+x^5+x^3+1 (0xA9), by repeated doubling.
   function automatic logic [7:0] mulxpow(input logic [7:0] c, input int n);
      int t;
      t = int'(c);
      for (int i = 0; i < n; i++) begin
         t = t * 2;
         if (t > 255) t = (t - 256) ^ 32'hA9;
      end
      return t[7:0];
   endfunction

   function automatic logic [31:0] ref_mul(input logic [31:0] s);
      logic [7:0] c;
      c = s[31:24];
      return {s[23:0], 8'h00} ^
             {mulxpow(c, 23), mulxpow(c, 245), mulxpow(c, 48), mulxpow(c, 239)};
   endfunction

   // Per-cycle model: a word is pending from accept until the handoff, visible after LAT edges.
   logic        m_pending = 1'b0;
   int          m_ticks   = 0;
   logic [31:0] m_exp     = 32'd0;
   logic [31:0] m_prev    = 32'd0;

   always @(negedge clk) begin
      logic exp_valid;
      if (!rst_n) begin
         chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
         chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
         chk("rst_busy", {31'd0, busy}, 32'd0);
         chk("rst_out_word", out_word, 32'd0);
         m_pending = 1'b0;
         m_ticks   = 0;
         m_prev    = 32'd0;
      end else begin
         exp_valid = m_pending && (m_ticks >= LAT);
         chk("cyc_in_ready", {31'd0, in_ready}, {31'd0, !m_pending});
         chk("cyc_busy", {31'd0, busy}, {31'd0, m_pending});
         chk("cyc_out_valid", {31'd0, out_valid}, {31'd0, exp_valid});
         chk("cyc_out_word", out_word, exp_valid ? m_exp : m_prev);
         if (exp_valid && out_ready) begin
            m_pending = 1'b0;
            m_prev    = m_exp;
         end else if (m_pending) begin
            m_ticks++;
         end else if (in_valid) begin
            m_pending = 1'b1;
            m_ticks   = 0;
            m_exp     = ref_mul(in_word);
         end
      end
   end

   task automatic send(input logic [31:0] w);
      int n = 0;
      while (!in_ready && n < 600) begin
         @(posedge clk); #1;
         n++;
      end
      chk("accept_wait", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b1;
      in_word  = w;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_out(input bit noise, output int n);
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
         if (noise && !out_valid) begin
            in_valid  = 1'($urandom % 2);
            in_word   = $urandom;
            out_ready = 1'($urandom % 2);
         end
      end while (!out_valid && n < 400);
      in_valid  = 1'b0;
      out_ready = 1'b0;
      chk("valid_wait", {31'd0, out_valid}, 32'd1);
   endtask

   task automatic consume(input int hold);
      repeat (hold) begin
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("handoff_valid", {31'd0, out_valid}, 32'd0);
      chk("handoff_ready", {31'd0, in_ready}, 32'd1);
   endtask

   task automatic do_word(input logic [31:0] w, input logic [31:0] exp, input bit noise, input int hold);
      int lat;
      send(w);
      wait_out(noise, lat);
      chk("latency", lat, LAT);
      chk("result", out_word, exp);
      consume(hold);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      bit saw;
      logic [31:0] w;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_word   = 32'd0;
      out_ready = 1'b0;

      chk("model_01", ref_mul(32'h01000000), 32'hE19FCF13);
      chk("model_02", ref_mul(32'h02000000), 32'h6B973726);
      chk("model_mix", ref_mul(32'h01123456), 32'hF3AB9913);
      chk("model_zero", ref_mul(32'h00ABCDEF), 32'hABCDEF00);

      repeat (3) @(posedge clk);
      #1;
      chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
      chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
      chk("reset_out_word", out_word, 32'd0);
      chk("reset_busy", {31'd0, busy}, 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      do_word(32'h01000000, 32'hE19FCF13, 1'b0, 0);
      do_word(32'h02000000, 32'h6B973726, 1'b0, 2);
      do_word(32'h01123456, 32'hF3AB9913, 1'b1, 0);
      do_word(32'h00ABCDEF, 32'hABCDEF00, 1'b0, 1);

      // Backpressure with in_valid pulses; a word held across the handoff is taken one edge later.
      send(32'h01123456);
      wait_out(1'b1, lat);
      chk("bp_latency", lat, LAT);
      for (int i = 0; i < 20; i++) begin
         chk("bp_word", out_word, 32'hF3AB9913);
         chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
         chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
         in_valid = 1'(i % 2);
         in_word  = 32'h02000000;
         @(posedge clk); #1;
      end
      in_valid  = 1'b1;
      in_word   = 32'h02000000;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("bp_handoff_busy", {31'd0, busy}, 32'd0);
      chk("bp_handoff_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("bp_next_accept", {31'd0, busy}, 32'd1);
      wait_out(1'b0, lat);
      chk("bp_next_latency", lat, LAT);
      chk("bp_next_word", out_word, 32'h6B973726);
      consume(0);

      // Abort a run part-way through.
      send(32'h01000000);
      repeat (100) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
      chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
      chk("abort_out_word", out_word, 32'd0);
      chk("abort_busy", {31'd0, busy}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      saw = 1'b0;
      repeat (300) begin
         @(posedge clk); #1;
         if (out_valid) saw = 1'b1;
      end
      chk("abort_no_ghost", {31'd0, saw}, 32'd0);
      do_word(32'h01000000, 32'hE19FCF13, 1'b0, 0);

      for (int i = 0; i < 25; i++) begin
         w = $urandom;
         if (i % 4 == 0) w[31:24] = 8'h00;
         do_word(w, ref_mul(w), 1'b1, int'($urandom_range(0, 5)));
      end

      repeat (2) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
